prbs_gen_chk: RTL

PRBS_GEN_CHK -- requirements
Module: prbs_gen_chk

---
 rtl/prbs_gen_chk.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/prbs_gen_chk.sv
// PRBS word generator (Fibonacci LFSR) with an independent self-synchronising checker.
// The checker hunts for lock, counts bit errors while locked and drops lock on sustained bad words.
module prbs_gen_chk #(
  parameter int WIDTH     = 8,
  parameter int LOCK_CNT  = 4,
  parameter int LOSS_CNT  = 4,
  parameter int ERR_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           poly_sel,
  input  logic                 gen_en,
  input  logic                 err_inj,
  output logic [WIDTH-1:0]     gen_data,
  output logic                 gen_valid,
  input  logic                 chk_valid,
  input  logic [WIDTH-1:0]     chk_data,
  input  logic                 err_cnt_clr,
  output logic                 locked,
  output logic                 bit_err,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  localparam int SW   = 31;
  localparam int CW   = $clog2(WIDTH + 1);
  localparam int RMAX = (LOCK_CNT > LOSS_CNT) ? LOCK_CNT : LOSS_CNT;
  localparam int RW   = $clog2(RMAX + 1);
  localparam int SUMW = ((ERR_CNT_W > CW) ? ERR_CNT_W : CW) + 1;

  localparam logic [CW-1:0]    BAD_THR   = CW'(WIDTH / 2);
  localparam logic [RW-1:0]    LOCK_LAST = RW'(LOCK_CNT - 1);
  localparam logic [RW-1:0]    LOSS_LAST = RW'(LOSS_CNT - 1);
  localparam logic [WIDTH-1:0] MSB_BIT   = WIDTH'(1) << (WIDTH - 1);

  typedef enum logic {HUNT = 1'b0, LOCKED = 1'b1} state_t;

  function automatic logic [4:0] tap_a(input logic [1:0] p);
    case (p)
      2'd0:    tap_a = 5'd6;
      2'd1:    tap_a = 5'd14;
      2'd2:    tap_a = 5'd22;
      default: tap_a = 5'd30;
    endcase
  endfunction

  function automatic logic [4:0] tap_b(input logic [1:0] p);
    case (p)
      2'd0:    tap_b = 5'd5;
      2'd1:    tap_b = 5'd13;
      2'd2:    tap_b = 5'd17;
      default: tap_b = 5'd27;
    endcase
  endfunction

  function automatic logic [SW-1:0] poly_mask(input logic [1:0] p);
    case (p)
      2'd0:    poly_mask = 31'h0000_007F;
      2'd1:    poly_mask = 31'h0000_7FFF;
      2'd2:    poly_mask = 31'h007F_FFFF;
      default: poly_mask = 31'h7FFF_FFFF;
    endcase
  endfunction

  function automatic logic [CW-1:0] popcount(input logic [WIDTH-1:0] v);
    popcount = '0;
    for (int i = 0; i < WIDTH; i++) begin
      popcount = popcount + CW'(v[i]);
    end
  endfunction

  function automatic logic [ERR_CNT_W-1:0] sat_add(input logic [ERR_CNT_W-1:0] acc,
                                                   input logic [CW-1:0]        inc);
    logic [SUMW-1:0] sum;
    logic [SUMW-1:0] lim;
    sum = SUMW'(acc) + SUMW'(inc);
    lim = SUMW'({ERR_CNT_W{1'b1}});
    sat_add = (sum > lim) ? {ERR_CNT_W{1'b1}} : sum[ERR_CNT_W-1:0];
  endfunction

  logic [1:0]       poly_p0;
  logic             poly_chg;
  logic [4:0]       ta, tb;
  logic [SW-1:0]    mask;

  logic [SW-1:0]    lfsr, lfsr_nxt;
  logic [WIDTH-1:0] word_nxt;

  logic [SW-1:0]    hist, hist_nxt;
  logic [WIDTH-1:0] err_bits;
  logic [CW-1:0]    nerr;

  state_t               state, state_nxt;
  logic [RW-1:0]        clean_run, clean_nxt;
  logic [RW-1:0]        bad_run, bad_nxt;
  logic [ERR_CNT_W-1:0] err_cnt_nxt;
  logic                 bit_err_nxt;

  // Taps follow the registered selection so a change takes effect together with the reseed
  always_comb begin
    poly_chg = (poly_sel != poly_p0);
    ta       = tap_a(poly_p0);
    tb       = tap_b(poly_p0);
    mask     = poly_mask(poly_p0);
  end

  always_comb begin : gen_comb
    logic nb;
    nb       = 1'b0;
    word_nxt = '0;
    lfsr_nxt = ((lfsr & mask) == '0) ? mask : lfsr;
    for (int i = 0; i < WIDTH; i++) begin
      nb                   = lfsr_nxt[ta] ^ lfsr_nxt[tb];
      lfsr_nxt             = {lfsr_nxt[SW-2:0], nb} & mask;
      word_nxt[WIDTH-1-i]  = nb;
    end
  end

  always_comb begin : chk_comb
    logic rx;
    logic pred;
    rx       = 1'b0;
    pred     = 1'b0;
    err_bits = '0;
    hist_nxt = hist;
    for (int i = 0; i < WIDTH; i++) begin
      rx                  = chk_data[WIDTH-1-i];
      pred                = hist_nxt[ta] ^ hist_nxt[tb];
      err_bits[WIDTH-1-i] = pred ^ rx;
      hist_nxt            = {hist_nxt[SW-2:0], rx} & mask;
    end
    nerr = popcount(err_bits);
  end

  // Lock FSM: next state, run counters and error accounting
  always_comb begin
    state_nxt   = state;
    clean_nxt   = clean_run;
    bad_nxt     = bad_run;
    bit_err_nxt = 1'b0;
    err_cnt_nxt = err_cnt;
    if (poly_chg) begin
      state_nxt = HUNT;
      clean_nxt = '0;
      bad_nxt   = '0;
    end else if (chk_valid) begin
      case (state)
        HUNT: begin
          if (nerr == '0 && hist_nxt != '0) begin
            if (clean_run == LOCK_LAST) begin
              state_nxt = LOCKED;
              clean_nxt = '0;
              bad_nxt   = '0;
            end else begin
              clean_nxt = clean_run + 1'b1;
            end
          end else begin
            clean_nxt = '0;
          end
        end
        default: begin
          bit_err_nxt = (nerr != '0);
          err_cnt_nxt = sat_add(err_cnt, nerr);
          if (nerr > BAD_THR) begin
            if (bad_run == LOSS_LAST) begin
              state_nxt = HUNT;
              bad_nxt   = '0;
              clean_nxt = '0;
            end else begin
              bad_nxt = bad_run + 1'b1;
            end
          end else begin
            bad_nxt = '0;
          end
        end
      endcase
    end
    if (err_cnt_clr) begin
      err_cnt_nxt = '0;
    end
  end

  // Stage p0: registered polynomial select, generator state and output word
  always_ff @(posedge clk) begin
    poly_p0 <= poly_sel;
    if (rst) begin
      lfsr      <= '1;
      gen_data  <= '0;
      gen_valid <= 1'b0;
    end else if (poly_chg) begin
      lfsr      <= '1;
      gen_valid <= 1'b0;
    end else if (gen_en) begin
      lfsr      <= lfsr_nxt;
      gen_data  <= word_nxt ^ (err_inj ? MSB_BIT : '0);
      gen_valid <= 1'b1;
    end else begin
      gen_valid <= 1'b0;
    end
  end

  // Stage p0: checker history and lock/error state
  always_ff @(posedge clk) begin
    if (rst) begin
      hist <= '0;
    end else if (chk_valid && !poly_chg) begin
      hist <= hist_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= HUNT;
      clean_run <= '0;
      bad_run   <= '0;
      err_cnt   <= '0;
      bit_err   <= 1'b0;
    end else begin
      state     <= state_nxt;
      clean_run <= clean_nxt;
      bad_run   <= bad_nxt;
      err_cnt   <= err_cnt_nxt;
      bit_err   <= bit_err_nxt;
    end
  end

  assign locked = (state == LOCKED);

endmodule
